prism_cfg_sequencer: RTL and testbench

- Command-queue sequencer that loads PRISM configuration and state-table words into the PRISM debug/config write port without CPU cycle-by-cycle involvement.
- The host pushes (address, data) pairs into an internal FIFO, then issues start. The block optionally pulses PRISM reset, then drains the FIFO one write at a time.
- Each write is followed by a settle gap so the delayed latch-register write path completes. Direct host writes share the same port and always win arbitration.

---
 rtl/prism_cfg_sequencer_if.sv | 43 ++++
 rtl/prism_cfg_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_prism_cfg_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prism_cfg_sequencer_if.sv
// Host/target bundle for prism_cfg_sequencer: command push port, run control,
// direct host write path, PRISM debug/config write port and status.
interface prism_cfg_sequencer_if #(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          cmd_valid;
  logic          cmd_ready;
  logic [5:0]    cmd_addr;
  logic [31:0]   cmd_data;
  logic          start;
  logic          start_rst;
  logic          abort;
  logic          host_wr;
  logic [5:0]    host_addr;
  logic [31:0]   host_wdata;
  logic          tgt_wr;
  logic [5:0]    tgt_addr;
  logic [31:0]   tgt_wdata;
  logic [31:0]   tgt_rdata;
  logic          tgt_reset;
  logic          tgt_hold;
  logic          busy;
  logic [LW-1:0] level;
  logic          done_irq;
  logic          irq_clr;
  logic          err;

  modport master (
    output cmd_valid, cmd_addr, cmd_data, start, start_rst, abort,
           host_wr, host_addr, host_wdata, tgt_rdata, irq_clr,
    input  cmd_ready, tgt_wr, tgt_addr, tgt_wdata, tgt_reset, tgt_hold,
           busy, level, done_irq, err
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_data, start, start_rst, abort,
           host_wr, host_addr, host_wdata, tgt_rdata, irq_clr,
    output cmd_ready, tgt_wr, tgt_addr, tgt_wdata, tgt_reset, tgt_hold,
           busy, level, done_irq, err
  );
endinterface

// File: rtl/prism_cfg_sequencer.sv
// Command-queue sequencer draining (addr,data) pairs into the PRISM config port.
// Optional PRISM_SEQ_READBACK_EN adds a post-gap readback CHECK with sticky err.
module prism_cfg_sequencer #(
  parameter int DEPTH      = 4,
  parameter int GAP        = 3,
  parameter int RST_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  prism_cfg_sequencer_if.slave bus
);
  localparam int ADDR_W = 6;
  localparam int DATA_W = 32;
  localparam int PW     = $clog2(DEPTH);
  localparam int LW     = PW + 1;
  localparam int GW     = $clog2(GAP + 1);
  localparam int RW     = $clog2(RST_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_ISSUE, S_GAP, S_CHECK, S_DONE
  } state_t;

  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     count;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;

  state_t            state_q, state_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic [RW-1:0]     rst_cnt_q, rst_cnt_d;
  logic              seq_wr, push, pop, flush, set_done, set_err;
  logic              done_irq_q;
  logic [ADDR_W-1:0] last_addr_q;

  assign head_addr     = mem_addr[rd_ptr];
  assign head_data     = mem_data[rd_ptr];
  assign bus.cmd_ready = (count != LW'(DEPTH));
  assign push          = bus.cmd_valid && bus.cmd_ready && !flush;
  assign pop           = seq_wr && !flush;

`ifdef PRISM_SEQ_READBACK_EN
  logic              err_q;
  logic [DATA_W-1:0] last_data_q;
  logic              rb_mismatch;

  assign rb_mismatch = (bus.tgt_rdata != last_data_q);
  assign bus.err     = err_q;
`else
  logic unused_rdata;

  assign unused_rdata = ^bus.tgt_rdata;
  assign bus.err      = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    rst_cnt_d = rst_cnt_q;
    seq_wr    = 1'b0;
    flush     = 1'b0;
    set_done  = 1'b0;
    set_err   = 1'b0;
    // The sequenced strobe yields to a host write; a strobe coincident with abort still goes out.
    if (state_q == S_ISSUE && !bus.host_wr) seq_wr = 1'b1;
    if (bus.abort) begin
      flush   = 1'b1;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if (count != '0) begin
              rst_cnt_d = '0;
              state_d   = bus.start_rst ? S_RST : S_ISSUE;
            end else begin
              set_done = 1'b1;
              state_d  = S_DONE;
            end
          end
        end
        S_RST: begin
          if (rst_cnt_q == RW'(RST_CYCLES - 1)) state_d = S_ISSUE;
          else rst_cnt_d = rst_cnt_q + 1'b1;
        end
        S_ISSUE: begin
          if (!bus.host_wr) begin
            gap_cnt_d = '0;
            state_d   = S_GAP;
          end
        end
        S_GAP: begin
          // A host write lands on the same latch path, so the settle window starts over.
          if (bus.host_wr) begin
            gap_cnt_d = '0;
          end else if (gap_cnt_q == GW'(GAP - 1)) begin
`ifdef PRISM_SEQ_READBACK_EN
            state_d = S_CHECK;
`else
            if (count != '0) begin
              state_d = S_ISSUE;
            end else begin
              set_done = 1'b1;
              state_d  = S_DONE;
            end
`endif
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
`ifdef PRISM_SEQ_READBACK_EN
        S_CHECK: begin
          if (rb_mismatch) begin
            set_err  = 1'b1;
            flush    = 1'b1;
            set_done = 1'b1;
            state_d  = S_DONE;
          end else if (count != '0) begin
            state_d = S_ISSUE;
          end else begin
            set_done = 1'b1;
            state_d  = S_DONE;
          end
        end
`endif
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      gap_cnt_q   <= '0;
      rst_cnt_q   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      last_addr_q <= '0;
      done_irq_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      rst_cnt_q <= rst_cnt_d;
      if (seq_wr) last_addr_q <= head_addr;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + LW'(push) - LW'(pop);
      end
      if (set_done)         done_irq_q <= 1'b1;
      else if (bus.irq_clr) done_irq_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= bus.cmd_addr;
      mem_data[wr_ptr] <= bus.cmd_data;
    end
  end

`ifdef PRISM_SEQ_READBACK_EN
  always_ff @(posedge clk) begin
    if (seq_wr) last_data_q <= head_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       err_q <= 1'b0;
    else if (set_err)                 err_q <= 1'b1;
    else if (bus.irq_clr && !set_done) err_q <= 1'b0;
  end
`endif

  assign bus.tgt_wr    = bus.host_wr | seq_wr;
  assign bus.tgt_addr  = bus.host_wr ? bus.host_addr  : (seq_wr ? head_addr : last_addr_q);
  assign bus.tgt_wdata = bus.host_wr ? bus.host_wdata : (seq_wr ? head_data : '0);
  assign bus.tgt_reset = (state_q == S_RST);
  assign bus.tgt_hold  = (state_q != S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.level     = count;
  assign bus.done_irq  = done_irq_q;
endmodule

// File: tb/tb_prism_cfg_sequencer.sv
// Randomized bench for prism_cfg_sequencer against a queue-based run model,
// plus directed scenarios pinned with literal expectations.
module tb_prism_cfg_sequencer;
  localparam int DEPTH      = 4;
  localparam int GAP        = 3;
  localparam int RST_CYCLES = 2;

  typedef struct packed {
    logic [5:0]  a;
    logic [31:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prism_cfg_sequencer_if #(.DEPTH(DEPTH)) bus ();

  prism_cfg_sequencer #(.DEPTH(DEPTH), .GAP(GAP), .RST_CYCLES(RST_CYCLES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Run model: pending entries, plus counters describing where the current run stands.
  ent_t        q[$];
  bit          m_active, m_fin, m_chk, m_done, m_err;
  int          m_rst_left, m_settle_left;
  logic [5:0]  m_last_addr;
  logic [31:0] m_last_data;
  bit          rd_corrupt = 1'b0;

  int          wr_cyc[$];
  logic [5:0]  wr_a[$];
  logic [31:0] wr_d[$];
  int          rst_cyc[$];

  assign bus.tgt_rdata = rd_corrupt ? 32'hDEAD_BEEF : m_last_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_active = 0; m_fin = 0; m_chk = 0; m_done = 0; m_err = 0;
    m_rst_left = 0; m_settle_left = 0;
    m_last_addr = '0; m_last_data = '0;
  endtask

  task automatic model_step();
    bit          issue, sw, ew, sd, se, fl, can_push;
    int          lvl;
    logic [5:0]  ea;
    logic [31:0] ed;
    logic [31:0] rd;
    lvl      = q.size();
    can_push = (lvl < DEPTH);
    rd       = bus.tgt_rdata;
    issue = m_active && m_rst_left == 0 && m_settle_left == 0 && !m_fin && !m_chk;
    sw    = issue && !bus.host_wr && rst_n;
    ew    = bus.host_wr | sw;
    ea    = bus.host_wr ? bus.host_addr  : (sw ? q[0].a : m_last_addr);
    ed    = bus.host_wr ? bus.host_wdata : (sw ? q[0].d : 32'h0);

    chk("tgt_wr", bus.tgt_wr, ew);
    if (ew || !rst_n || (m_chk && !bus.host_wr)) chk("tgt_addr", bus.tgt_addr, ea);
    if (ew || !rst_n) chk("tgt_wdata", bus.tgt_wdata, ed);
    chk("busy", bus.busy, m_active);
    chk("tgt_hold", bus.tgt_hold, m_active);
    chk("tgt_reset", bus.tgt_reset, m_active && m_rst_left > 0);
    chk("level", bus.level, lvl);
    chk("cmd_ready", bus.cmd_ready, can_push);
    chk("done_irq", bus.done_irq, m_done);
    chk("err", bus.err, m_err);

    if (bus.tgt_wr === 1'b1) begin
      wr_cyc.push_back(cyc); wr_a.push_back(bus.tgt_addr); wr_d.push_back(bus.tgt_wdata);
    end
    if (bus.tgt_reset === 1'b1) rst_cyc.push_back(cyc);
    if (!rst_n) return;

    sd = 0; se = 0; fl = 0;
    if (sw) begin m_last_addr = q[0].a; m_last_data = q[0].d; end
    if (bus.abort) begin
      fl = 1;
      m_active = 0; m_fin = 0; m_chk = 0; m_rst_left = 0; m_settle_left = 0;
    end else begin
      if (sw) void'(q.pop_front());
      if (!m_active) begin
        if (bus.start) begin
          m_active = 1;
          if (lvl > 0) m_rst_left = bus.start_rst ? RST_CYCLES : 0;
          else begin m_fin = 1; sd = 1; end
        end
      end else if (m_fin) begin
        m_active = 0; m_fin = 0;
      end else if (m_rst_left > 0) begin
        m_rst_left--;
      end else if (m_chk) begin
        m_chk = 0;
        if (rd !== m_last_data) begin se = 1; fl = 1; m_fin = 1; sd = 1; end
        else if (lvl == 0) begin m_fin = 1; sd = 1; end
      end else if (m_settle_left > 0) begin
        if (bus.host_wr) m_settle_left = GAP;
        else begin
          m_settle_left--;
          if (m_settle_left == 0) begin
`ifdef PRISM_SEQ_READBACK_EN
            m_chk = 1;
`else
            if (lvl == 0) begin m_fin = 1; sd = 1; end
`endif
          end
        end
      end else if (sw) begin
        m_settle_left = GAP;
      end
    end
    if (fl) q.delete();
    else if (bus.cmd_valid && can_push) q.push_back('{a: bus.cmd_addr, d: bus.cmd_data});
    if (sd) m_done = 1;
    else if (bus.irq_clr) begin m_done = 0; m_err = 0; end
    if (se) m_err = 1;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!rst_n) model_reset();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.cmd_valid = 0; bus.cmd_addr = '0; bus.cmd_data = '0;
    bus.start = 0; bus.start_rst = 0; bus.abort = 0; bus.irq_clr = 0;
    bus.host_wr = 0; bus.host_addr = '0; bus.host_wdata = '0;
  endtask

  task automatic push(input logic [5:0] a, input logic [31:0] d);
    bus.cmd_valid = 1; bus.cmd_addr = a; bus.cmd_data = d;
    tick();
    bus.cmd_valid = 0;
  endtask

  task automatic pulse_start(input bit r);
    bus.start = 1; bus.start_rst = r;
    tick();
    bus.start = 0; bus.start_rst = 0;
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    while (bus.done_irq !== 1'b1 && n < maxc) begin tick(); n++; end
    chk("wait_done_timeout", bus.done_irq, 1'b1);
  endtask

  task automatic clear_irq();
    bus.irq_clr = 1; tick(); bus.irq_clr = 0; tick();
  endtask

  initial begin
    int b, br, n;
    quiet();
    model_reset();
    repeat (3) tick();
    chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_level", bus.level, 0);
    rst_n = 1;
    tick();

    // Two entries, no reset pulse: writes 1+GAP apart.
    push(6'h00, 32'h2000_0001);
    push(6'h20, 32'h0500_0010);
    b = wr_cyc.size();
    pulse_start(0);
    wait_done(40);
    chk("t1_done", bus.done_irq, 1'b1);
    repeat (2) tick();
    chk("t1_nwr", wr_cyc.size() - b, 2);
    if (wr_cyc.size() - b >= 2) begin
      chk("t1_a0", wr_a[b], 6'h00);
      chk("t1_d0", wr_d[b], 32'h2000_0001);
      chk("t1_a1", wr_a[b+1], 6'h20);
      chk("t1_d1", wr_d[b+1], 32'h0500_0010);
      chk("t1_spacing", wr_cyc[b+1] - wr_cyc[b], 4);
    end
    chk("t1_busy", bus.busy, 1'b0);
    chk("t1_level", bus.level, 0);
    clear_irq();
    chk("t1_irq_clr", bus.done_irq, 1'b0);

    // Reset pulse ahead of a single write.
    push(6'h11, 32'hCAFE_0001);
    b = wr_cyc.size(); br = rst_cyc.size();
    pulse_start(1);
    wait_done(40);
    chk("t2_nrst", rst_cyc.size() - br, 2);
    chk("t2_nwr", wr_cyc.size() - b, 1);
    if (wr_cyc.size() > b && rst_cyc.size() > br)
      chk("t2_rst_lead", wr_cyc[b] - rst_cyc[br], 2);
    clear_irq();

    // Overfill: fifth push dropped.
    bus.cmd_valid = 1;
    for (int i = 0; i < 5; i++) begin
      bus.cmd_addr = 6'(i + 1); bus.cmd_data = 32'h100 + i; tick();
    end
    bus.cmd_valid = 0;
    chk("t3_level_full", bus.level, 4);
    chk("t3_cmd_ready", bus.cmd_ready, 1'b0);
    b = wr_cyc.size();
    pulse_start(0);
    wait_done(60);
    chk("t3_nwr", wr_cyc.size() - b, 4);
    if (wr_cyc.size() - b >= 4) chk("t3_last_d", wr_d[b+3], 32'h103);
    clear_irq();

    // Host writes stall ISSUE for three cycles.
    push(6'h05, 32'h55);
    b = wr_cyc.size();
    pulse_start(0);
    bus.host_wr = 1; bus.host_addr = 6'h3F; bus.host_wdata = 32'hAAAA;
    repeat (3) tick();
    bus.host_wr = 0;
    wait_done(40);
    chk("t4_nwr", wr_cyc.size() - b, 4);
    if (wr_cyc.size() - b >= 4) begin
      chk("t4_host_a", wr_a[b], 6'h3F);
      chk("t4_seq_a", wr_a[b+3], 6'h05);
      chk("t4_seq_d", wr_d[b+3], 32'h55);
      chk("t4_seq_delay", wr_cyc[b+3] - wr_cyc[b], 3);
    end
    clear_irq();

    // Abort in GAP with two entries left.
    push(6'h01, 32'h1); push(6'h02, 32'h2); push(6'h03, 32'h3);
    b = wr_cyc.size();
    pulse_start(0);
    n = 0;
    while (wr_cyc.size() == b && n < 10) begin tick(); n++; end
    chk("t5_first_wr", wr_cyc.size() - b, 1);
    bus.abort = 1; tick(); bus.abort = 0;
    repeat (12) tick();
    chk("t5_nwr", wr_cyc.size() - b, 1);
    chk("t5_level", bus.level, 0);
    chk("t5_done", bus.done_irq, 1'b0);
    chk("t5_busy", bus.busy, 1'b0);

`ifdef PRISM_SEQ_READBACK_EN
    // Corrupted readback ends the run with err and flushes the rest.
    rd_corrupt = 1;
    push(6'h01, 32'h0000_0001); push(6'h02, 32'h0000_0002);
    b = wr_cyc.size();
    pulse_start(0);
    wait_done(40);
    chk("t6_err", bus.err, 1'b1);
    chk("t6_nwr", wr_cyc.size() - b, 1);
    chk("t6_level", bus.level, 0);
    rd_corrupt = 0;
    repeat (2) tick();
    clear_irq();
    chk("t6_err_clr", bus.err, 1'b0);
`endif

    // Randomized traffic with one asynchronous reset mid-run.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        quiet();
        rst_n = 0; tick(); tick(); rst_n = 1;
      end
      bus.cmd_valid  = ($urandom_range(0, 1) == 1);
      bus.cmd_addr   = 6'($urandom);
      bus.cmd_data   = $urandom;
      bus.start      = ($urandom_range(0, 15) == 0);
      bus.start_rst  = ($urandom_range(0, 1) == 1);
      bus.abort      = ($urandom_range(0, 63) == 0);
      bus.host_wr    = ($urandom_range(0, 9) == 0);
      bus.host_addr  = 6'($urandom);
      bus.host_wdata = $urandom;
      bus.irq_clr    = ($urandom_range(0, 19) == 0);
      tick();
    end
    quiet();
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
